// File: rtl/param_delay_line.sv
// -----------------------------------------------------------------------------
// param_delay_line
//
// Parametrised register delay line. WIDTH-bit data and a valid flag are
// shifted together through DEPTH register stages. The line has a shift
// enable, a synchronous flush, an asynchronous active-low reset and a
// saturating fill counter that raises "primed" once DEPTH enabled shifts
// have happened since the last reset or flush. Typical use is aligning
// datapaths whose pipeline latencies differ.
//
// Optional feature macro: DELAY_TAP_SEL_EN
//   When defined, a tap port selects any stage for combinational read-out.
//   When undefined, the tap ports and their mux do not exist.
//
// Parameters
//   WIDTH  data bits per stage (>= 1)
//   DEPTH  number of stages = latency in enabled cycles (>= 1)
//   CNT_W  fill-counter width, derived from DEPTH (not overridable)
//
// Ports
//   clk       in   1       rising-edge clock
//   rst_n     in   1       asynchronous active-low reset
//   ce        in   1       shift enable; low holds every stage
//   flush     in   1       synchronous clear of stages, valids and fill count
//   din       in   WIDTH   input data
//   din_vld   in   1       input valid
//   dout      out  WIDTH   data of the last stage
//   dout_vld  out  1       valid of the last stage
//   primed    out  1       DEPTH enabled shifts seen since reset/flush
//   tap_sel   in   CNT_W   stage index to read (DELAY_TAP_SEL_EN only)
//   tap_dout  out  WIDTH   data of stage tap_sel (DELAY_TAP_SEL_EN only)
//   tap_vld   out  1       valid of stage tap_sel (DELAY_TAP_SEL_EN only)
// -----------------------------------------------------------------------------
module param_delay_line #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 3,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ce,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    input  logic             din_vld,
    output logic [WIDTH-1:0] dout,
    output logic             dout_vld,
    output logic             primed
`ifdef DELAY_TAP_SEL_EN
    ,
    input  logic [CNT_W-1:0] tap_sel,
    output logic [WIDTH-1:0] tap_dout,
    output logic             tap_vld
`endif
);

    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1'b1);

    // Stage 0 is the newest sample, stage DEPTH-1 feeds dout.
    logic [WIDTH-1:0] data_q [DEPTH];
    logic [WIDTH-1:0] data_d [DEPTH];
    logic [DEPTH-1:0] vld_q;
    logic [DEPTH-1:0] vld_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             primed_q;
    logic             primed_d;

    // Next-state of stages and fill counter: flush beats ce, ce beats hold.
    always_comb begin
        data_d   = data_q;
        vld_d    = vld_q;
        cnt_d    = cnt_q;
        primed_d = primed_q;
        if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_d[i] = {WIDTH{1'b0}};
            end
            vld_d    = {DEPTH{1'b0}};
            cnt_d    = {CNT_W{1'b0}};
            primed_d = 1'b0;
        end else if (ce) begin
            // Data moves even when din_vld is low; the valid travels with it.
            data_d[0] = din;
            vld_d[0]  = din_vld;
            for (int i = 1; i < DEPTH; i++) begin
                data_d[i] = data_q[i-1];
                vld_d[i]  = vld_q[i-1];
            end
            if (cnt_q != DEPTH_CNT) begin
                cnt_d = cnt_q + CNT_ONE;
            end else begin
                cnt_d = cnt_q;
            end
            // primed is registered: it follows the counter value being loaded.
            primed_d = (cnt_d == DEPTH_CNT);
        end else begin
            data_d   = data_q;
            vld_d    = vld_q;
            cnt_d    = cnt_q;
            primed_d = primed_q;
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= {WIDTH{1'b0}};
            end
            vld_q    <= {DEPTH{1'b0}};
            cnt_q    <= {CNT_W{1'b0}};
            primed_q <= 1'b0;
        end else begin
            data_q   <= data_d;
            vld_q    <= vld_d;
            cnt_q    <= cnt_d;
            primed_q <= primed_d;
        end
    end

    // Outputs come straight from registers; no path from din to dout.
    always_comb begin
        dout     = data_q[DEPTH-1];
        dout_vld = vld_q[DEPTH-1];
        primed   = primed_q;
    end

`ifdef DELAY_TAP_SEL_EN
    logic [CNT_W-1:0] tap_idx;

    // Out-of-range selections read the last stage.
    always_comb begin
        if (tap_sel >= DEPTH_CNT) begin
            tap_idx = DEPTH_CNT - CNT_ONE;
        end else begin
            tap_idx = tap_sel;
        end
    end

    // Tap read mux over the registered stages.
    always_comb begin
        tap_dout = {WIDTH{1'b0}};
        tap_vld  = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (tap_idx == CNT_W'(i)) begin
                tap_dout = data_q[i];
                tap_vld  = vld_q[i];
            end else begin
                tap_dout = tap_dout;
                tap_vld  = tap_vld;
            end
        end
    end
`endif

endmodule

// File: tb/tb_param_delay_line.sv
// -----------------------------------------------------------------------------
// tb_param_delay_line
//
// Self-checking bench for param_delay_line. Two instances share inputs:
// DEPTH=3 (main) and DEPTH=1 (single-stage corner). The reference model is a
// history of samples accepted on enabled edges since the last reset/flush:
// a depth-D line outputs the sample accepted D pushes ago (or zero if fewer
// pushes happened), and is primed once D pushes have been seen.
// -----------------------------------------------------------------------------
module tb_param_delay_line;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             ce;
    logic             flush;
    logic [WIDTH-1:0] din;
    logic             din_vld;

    logic [WIDTH-1:0] dout3;
    logic             dout_vld3;
    logic             primed3;
    logic [WIDTH-1:0] dout1;
    logic             dout_vld1;
    logic             primed1;

    logic [1:0]       tap_sel3;
    logic [WIDTH-1:0] tap_dout3;
    logic             tap_vld3;
    logic [0:0]       tap_sel1;
    logic [WIDTH-1:0] tap_dout1;
    logic             tap_vld1;

    int errors;
    int checks;

    // Model state: accepted {vld,data} samples, oldest first.
    logic [8:0] hist[$];
    int         pushes;

    param_delay_line #(.WIDTH(WIDTH), .DEPTH(3)) u_dut3 (
        .clk      (clk),
        .rst_n    (rst_n),
        .ce       (ce),
        .flush    (flush),
        .din      (din),
        .din_vld  (din_vld),
        .dout     (dout3),
        .dout_vld (dout_vld3),
        .primed   (primed3)
`ifdef DELAY_TAP_SEL_EN
        ,
        .tap_sel  (tap_sel3),
        .tap_dout (tap_dout3),
        .tap_vld  (tap_vld3)
`endif
    );

    param_delay_line #(.WIDTH(WIDTH), .DEPTH(1)) u_dut1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .ce       (ce),
        .flush    (flush),
        .din      (din),
        .din_vld  (din_vld),
        .dout     (dout1),
        .dout_vld (dout_vld1),
        .primed   (primed1)
`ifdef DELAY_TAP_SEL_EN
        ,
        .tap_sel  (tap_sel1),
        .tap_dout (tap_dout1),
        .tap_vld  (tap_vld1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void model_clear();
        hist.delete();
        pushes = 0;
    endfunction

    // Expected {data, vld, primed} for a line of the given depth.
    function automatic logic [9:0] exp_out(int depth);
        logic [8:0] s;
        s = 9'd0;
        if (hist.size() >= depth) s = hist[hist.size() - depth];
        return {s[7:0], s[8], (pushes >= depth) ? 1'b1 : 1'b0};
    endfunction

    // Expected {vld, data} of the k-th newest sample, clamped to the depth.
    function automatic logic [8:0] exp_tap(int depth, int sel);
        int k;
        k = (sel >= depth) ? depth - 1 : sel;
        if (hist.size() > k) return hist[hist.size() - 1 - k];
        return 9'd0;
    endfunction

    // Advance one clock edge, update the model, settle outputs.
    task automatic step();
        @(posedge clk);
        if (rst_n) begin
            if (flush) begin
                model_clear();
            end else if (ce) begin
                hist.push_back({din_vld, din});
                if (hist.size() > 8) void'(hist.pop_front());
                pushes++;
            end
        end
        #1;
    endtask

    task automatic drive(input logic c, input logic f, input logic [7:0] d, input logic v);
        ce      = c;
        flush   = f;
        din     = d;
        din_vld = v;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        tap_sel3 = 2'd0;
        tap_sel1 = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({dout3, dout_vld3, primed3} !== 10'h000) begin
            errors++;
            $display("FAIL reset_d3 got=%h exp=%h", {dout3, dout_vld3, primed3}, 10'h000);
        end
        checks++;
        if ({dout1, dout_vld1, primed1} !== 10'h000) begin
            errors++;
            $display("FAIL reset_d1 got=%h exp=%h", {dout1, dout_vld1, primed1}, 10'h000);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_latency();
        logic [7:0] seq [4];
        seq[0] = 8'h11; seq[1] = 8'h22; seq[2] = 8'h33; seq[3] = 8'h44;
        drive(1'b1, 1'b1, 8'h00, 1'b0);
        step();
        for (int e = 0; e < 4; e++) begin
            drive(1'b1, 1'b0, seq[e], 1'b1);
            step();
            checks++;
            if ({dout3, dout_vld3, primed3} !== exp_out(3)) begin
                errors++;
                $display("FAIL latency_d3 edge=%0d got=%h exp=%h", e + 1, {dout3, dout_vld3, primed3}, exp_out(3));
            end
            checks++;
            if ({dout1, dout_vld1, primed1} !== exp_out(1)) begin
                errors++;
                $display("FAIL latency_d1 edge=%0d got=%h exp=%h", e + 1, {dout1, dout_vld1, primed1}, exp_out(1));
            end
            if (e == 1) begin
                checks++;
                if ({dout_vld3, primed3} !== 2'b00) begin
                    errors++;
                    $display("FAIL latency_early got=%b exp=%b", {dout_vld3, primed3}, 2'b00);
                end
            end
            if (e == 2) begin
                checks++;
                if ({dout3, dout_vld3, primed3} !== {8'h11, 1'b1, 1'b1}) begin
                    errors++;
                    $display("FAIL latency_edge3 got=%h exp=%h", {dout3, dout_vld3, primed3}, {8'h11, 1'b1, 1'b1});
                end
            end
        end
    endtask

    task automatic test_hold();
        drive(1'b1, 1'b1, 8'h00, 1'b0);
        step();
        drive(1'b1, 1'b0, 8'hA5, 1'b1);
        step();
        for (int c = 0; c < 5; c++) begin
            drive(1'b0, 1'b0, 8'($urandom), 1'($urandom));
            step();
            checks++;
            if ({dout3, dout_vld3, primed3} !== exp_out(3) || {dout1, dout_vld1, primed1} !== exp_out(1)) begin
                errors++;
                $display("FAIL hold cyc=%0d got=%h/%h exp=%h/%h", c, {dout3, dout_vld3, primed3},
                         {dout1, dout_vld1, primed1}, exp_out(3), exp_out(1));
            end
        end
        for (int c = 0; c < 2; c++) begin
            drive(1'b1, 1'b0, 8'h00, 1'b0);
            step();
        end
        checks++;
        if ({dout3, dout_vld3, primed3} !== {8'hA5, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL hold_resume got=%h exp=%h", {dout3, dout_vld3, primed3}, {8'hA5, 1'b1, 1'b1});
        end
    endtask

    task automatic test_flush_vs_ce();
        for (int c = 0; c < 4; c++) begin
            drive(1'b1, 1'b0, 8'(8'h60 + c), 1'b1);
            step();
        end
        drive(1'b1, 1'b1, 8'hFF, 1'b1);
        step();
        checks++;
        if ({dout3, dout_vld3, primed3} !== 10'h000 || {dout1, dout_vld1, primed1} !== 10'h000) begin
            errors++;
            $display("FAIL flush_vs_ce got=%h/%h exp=000/000", {dout3, dout_vld3, primed3}, {dout1, dout_vld1, primed1});
        end
        for (int c = 0; c < 3; c++) begin
            drive(1'b1, 1'b0, 8'h00, 1'b0);
            step();
            checks++;
            if ({dout3, dout_vld3, primed3} !== exp_out(3) || dout3 === 8'hFF) begin
                errors++;
                $display("FAIL flush_drain cyc=%0d got=%h exp=%h", c, {dout3, dout_vld3, primed3}, exp_out(3));
            end
        end
    endtask

    task automatic test_saturation();
        drive(1'b1, 1'b1, 8'h00, 1'b0);
        step();
        for (int c = 0; c < 20; c++) begin
            drive(1'b1, 1'b0, 8'($urandom), 1'($urandom));
            step();
            checks++;
            if ({dout3, dout_vld3, primed3} !== exp_out(3) || {dout1, dout_vld1, primed1} !== exp_out(1)) begin
                errors++;
                $display("FAIL saturation cyc=%0d got=%h/%h exp=%h/%h", c, {dout3, dout_vld3, primed3},
                         {dout1, dout_vld1, primed1}, exp_out(3), exp_out(1));
            end
        end
        checks++;
        if ({primed3, primed1} !== 2'b11) begin
            errors++;
            $display("FAIL saturation_primed got=%b exp=%b", {primed3, primed1}, 2'b11);
        end
    endtask

    task automatic test_reset_midstream();
        for (int c = 0; c < 4; c++) begin
            drive(1'b1, 1'b0, 8'(8'hC0 + c), 1'b1);
            step();
        end
        #2;
        rst_n = 1'b0;
        model_clear();
        #1;
        checks++;
        if ({dout3, dout_vld3, primed3} !== 10'h000 || {dout1, dout_vld1, primed1} !== 10'h000) begin
            errors++;
            $display("FAIL reset_midstream got=%h/%h exp=000/000", {dout3, dout_vld3, primed3}, {dout1, dout_vld1, primed1});
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            drive(($urandom_range(3, 0) != 0) ? 1'b1 : 1'b0,
                  ($urandom_range(15, 0) == 0) ? 1'b1 : 1'b0,
                  8'($urandom), 1'($urandom));
            step();
            checks++;
            if ({dout3, dout_vld3, primed3} !== exp_out(3) || {dout1, dout_vld1, primed1} !== exp_out(1)) begin
                errors++;
                $display("FAIL random cyc=%0d got=%h/%h exp=%h/%h", c, {dout3, dout_vld3, primed3},
                         {dout1, dout_vld1, primed1}, exp_out(3), exp_out(1));
            end
            if (c % 97 == 50) begin
                #2;
                rst_n = 1'b0;
                model_clear();
                #1;
                checks++;
                if ({dout3, dout_vld3, primed3, dout1, dout_vld1, primed1} !== 20'h00000) begin
                    errors++;
                    $display("FAIL random_reset cyc=%0d got=%h/%h exp=000/000", c, {dout3, dout_vld3, primed3},
                             {dout1, dout_vld1, primed1});
                end
                @(negedge clk);
                rst_n = 1'b1;
            end
        end
    endtask

`ifdef DELAY_TAP_SEL_EN
    task automatic test_tap();
        drive(1'b1, 1'b1, 8'h00, 1'b0);
        step();
        for (int c = 1; c <= 3; c++) begin
            drive(1'b1, 1'b0, 8'(c), 1'b1);
            step();
        end
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        for (int s = 0; s < 4; s++) begin
            tap_sel3 = 2'(s);
            tap_sel1 = 1'(s);
            #1;
            checks++;
            if ({tap_vld3, tap_dout3} !== exp_tap(3, s) || {tap_vld1, tap_dout1} !== exp_tap(1, s % 2)) begin
                errors++;
                $display("FAIL tap sel=%0d got=%h/%h exp=%h/%h", s, {tap_vld3, tap_dout3},
                         {tap_vld1, tap_dout1}, exp_tap(3, s), exp_tap(1, s % 2));
            end
        end
        tap_sel3 = 2'd3;
        #1;
        checks++;
        if ({tap_vld3, tap_dout3} !== {1'b1, 8'h01}) begin
            errors++;
            $display("FAIL tap_clamp got=%h exp=%h", {tap_vld3, tap_dout3}, {1'b1, 8'h01});
        end
        tap_sel3 = 2'd0;
        tap_sel1 = 1'b0;
    endtask
`endif

    initial begin
        errors = 0;
        checks = 0;
        tap_sel3 = 2'd0;
        tap_sel1 = 1'b0;
        test_reset();
        test_latency();
        test_hold();
        test_flush_vs_ce();
        test_saturation();
        test_reset_midstream();
`ifdef DELAY_TAP_SEL_EN
        test_tap();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
